// File: rtl/spi_master_shifter.sv
// SPI mode-0 master shift engine: pops a word from a FWFT TX FIFO, shifts it out MSB first,
// and pushes the word captured on MISO into the RX FIFO.
//
// Handshake: tx_pop and rx_push are single-cycle strobes with no back-pressure inside a transfer.
// tx_data is consumed on the edge that ends a cycle where tx_pop=1. rx_data is valid only while
// rx_push=1. A pop is issued only when the RX FIFO has room (rx_full=0).
module spi_master_shifter #(
    parameter int DWIDTH  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              enable,
    input  logic              tx_empty,
    input  logic [DWIDTH-1:0] tx_data,
    output logic              tx_pop,
    input  logic              rx_full,
    output logic [DWIDTH-1:0] rx_data,
    output logic              rx_push,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS_N,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DWIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DWIDTH-1:0] shreg;
    logic              miso_q;
    logic [HW-1:0]     hcnt;
    logic [BW-1:0]     bcnt;
    logic              tick;
    logic              last_bit;

    assign tick     = (hcnt == HW'(CLK_DIV - 1));
    assign last_bit = (bcnt == BW'(DWIDTH - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tx_pop   = 1'b0;
        case (state)
            IDLE: begin
                tx_pop = enable & ~tx_empty & ~rx_full;
                if (tx_pop) state_nx = START;
            end
            START:   if (tick) state_nx = SHIFT;
            SHIFT:   if (tick && SCLK && last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The first SCLK rise leaves START, so MISO is sampled on every 0->1 drive, START included.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            shreg   <= '0;
            miso_q  <= 1'b0;
            hcnt    <= '0;
            bcnt    <= '0;
            SCLK    <= 1'b0;
            CS_N    <= 1'b1;
            rx_data <= '0;
            rx_push <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_pop) begin
                        shreg <= tx_data;
                        CS_N  <= 1'b0;
                        hcnt  <= '0;
                        bcnt  <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        hcnt   <= '0;
                        SCLK   <= 1'b1;
                        miso_q <= MISO;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        hcnt <= '0;
                        if (!SCLK) begin
                            SCLK   <= 1'b1;
                            miso_q <= MISO;
                        end else begin
                            SCLK <= 1'b0;
                            if (last_bit) begin
                                rx_data <= {shreg[DWIDTH-2:0], miso_q};
                                rx_push <= 1'b1;
                                CS_N    <= 1'b1;
                            end else begin
                                shreg <= {shreg[DWIDTH-2:0], miso_q};
                                bcnt  <= bcnt + BW'(1);
                            end
                        end
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign MOSI      = ~CS_N & shreg[DWIDTH-1];
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench for spi_master_shifter (DWIDTH=8, CLK_DIV=2): loopback, MISO-high, back-to-back,
// flow control, enable drop and mid-transfer reset, with hand-computed expectations.
module tb_spi_master_shifter;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       enable;
    logic       tx_empty;
    logic [7:0] tx_data;
    logic       tx_pop;
    logic       rx_full;
    logic [7:0] rx_data;
    logic       rx_push;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       CS_N;
    logic       busy;
    logic [1:0] state_dbg;

    logic       loopback;
    logic       miso_val;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    bit         to;
    int         gap, cs_low, rises, lat, xpops, ovl;
    logic [7:0] mb, rx;

    assign MISO = loopback ? MOSI : miso_val;

    spi_master_shifter #(.DWIDTH(8), .CLK_DIV(2)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .enable(enable), .tx_empty(tx_empty),
        .tx_data(tx_data), .tx_pop(tx_pop), .rx_full(rx_full), .rx_data(rx_data),
        .rx_push(rx_push), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS_N(CS_N),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    // Measures one transfer: waits for the pop, presents the next FIFO head, then follows the
    // word until rx_push. Returns measurements only; the calling test decides what is right.
    task automatic run_transfer(input logic nx_empty, input logic [7:0] nx_word, input int drop_rise,
                                output bit t_o, output int g, output int csl, output int nr,
                                output logic [7:0] mbits, output logic [7:0] rxw, output int lt,
                                output int xp, output int ov);
        int   pop_cyc;
        logic prev_sclk;
        bit   done;
        t_o = 0; g = 0; csl = 0; nr = 0; mbits = '0; rxw = '0; lt = 0; xp = 0; ov = 0;
        #1;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (CS_N) g++;
            if (tx_pop) done = 1;
            else tick();
        end
        if (!done) begin
            t_o = 1;
            return;
        end
        pop_cyc = cyc;
        @(posedge PCLK);
        #1;
        tx_empty  = nx_empty;
        tx_data   = nx_word;
        prev_sclk = 1'b0;
        done      = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (!CS_N) csl++;
            if (SCLK && !prev_sclk) begin
                nr++;
                mbits = {mbits[6:0], MOSI};
                if (nr == drop_rise) enable = 1'b0;
            end
            prev_sclk = SCLK;
            if (tx_pop) xp++;
            if (tx_pop && rx_push) ov++;
            if (rx_push) begin
                rxw  = rx_data;
                lt   = cyc - pop_cyc;
                done = 1;
            end
        end
        if (!done) t_o = 1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1; enable = 1'b0; tx_empty = 1'b1; tx_data = 8'h00;
        rx_full = 1'b0; loopback = 1'b1; miso_val = 1'b0;
        repeat (3) tick();
        checks++; if (CS_N !== 1'b1)       begin errors++; $display("FAIL reset_cs_n got=%b exp=1", CS_N); end
        checks++; if (SCLK !== 1'b0)       begin errors++; $display("FAIL reset_sclk got=%b exp=0", SCLK); end
        checks++; if (MOSI !== 1'b0)       begin errors++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
        checks++; if (tx_pop !== 1'b0)     begin errors++; $display("FAIL reset_tx_pop got=%b exp=0", tx_pop); end
        checks++; if (rx_push !== 1'b0)    begin errors++; $display("FAIL reset_rx_push got=%b exp=0", rx_push); end
        checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (state_dbg !== 2'd0)  begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        PRESET = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_loopback();
        loopback = 1'b1; enable = 1'b1; tx_data = 8'hA5; tx_empty = 1'b0;
        run_transfer(1'b1, 8'h00, -1, to, gap, cs_low, rises, mb, rx, lat, xpops, ovl);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL lb_timeout got=%b exp=0", to); end
        checks++; if (cs_low != 32)   begin errors++; $display("FAIL lb_cs_low got=%0d exp=32", cs_low); end
        checks++; if (rises != 8)     begin errors++; $display("FAIL lb_sclk_rises got=%0d exp=8", rises); end
        checks++; if (mb !== 8'hA5)   begin errors++; $display("FAIL lb_mosi_bits got=%h exp=a5", mb); end
        checks++; if (rx !== 8'hA5)   begin errors++; $display("FAIL lb_rx_data got=%h exp=a5", rx); end
        checks++; if (lat != 33)      begin errors++; $display("FAIL lb_latency got=%0d exp=33", lat); end
        checks++; if (xpops != 0)     begin errors++; $display("FAIL lb_extra_pops got=%0d exp=0", xpops); end
        checks++; if (ovl != 0)       begin errors++; $display("FAIL lb_pop_push_overlap got=%0d exp=0", ovl); end
        tick();
        checks++; if (rx_push !== 1'b0) begin errors++; $display("FAIL lb_push_width got=%b exp=0", rx_push); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL lb_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_miso_high();
        loopback = 1'b0; miso_val = 1'b1; tx_data = 8'h3C; tx_empty = 1'b0;
        run_transfer(1'b1, 8'h00, -1, to, gap, cs_low, rises, mb, rx, lat, xpops, ovl);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL m1_timeout got=%b exp=0", to); end
        checks++; if (mb !== 8'h3C)   begin errors++; $display("FAIL m1_mosi_bits got=%h exp=3c", mb); end
        checks++; if (rx !== 8'hFF)   begin errors++; $display("FAIL m1_rx_data got=%h exp=ff", rx); end
        loopback = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        tx_data = 8'h12; tx_empty = 1'b0;
        run_transfer(1'b0, 8'h34, -1, to, gap, cs_low, rises, mb, rx, lat, xpops, ovl);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL b2b0_timeout got=%b exp=0", to); end
        checks++; if (rx !== 8'h12)   begin errors++; $display("FAIL b2b0_rx_data got=%h exp=12", rx); end
        checks++; if (lat != 33)      begin errors++; $display("FAIL b2b0_latency got=%0d exp=33", lat); end
        run_transfer(1'b1, 8'h00, -1, to, gap, cs_low, rises, mb, rx, lat, xpops, ovl);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL b2b1_timeout got=%b exp=0", to); end
        checks++; if (gap != 2)       begin errors++; $display("FAIL b2b_cs_high_gap got=%0d exp=2", gap); end
        checks++; if (rx !== 8'h34)   begin errors++; $display("FAIL b2b1_rx_data got=%h exp=34", rx); end
        checks++; if (lat != 33)      begin errors++; $display("FAIL b2b1_latency got=%0d exp=33", lat); end
        tick();
    endtask

    task automatic test_flow_control();
        rx_full = 1'b1; tx_data = 8'h77; tx_empty = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (tx_pop !== 1'b0 || CS_N !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL flow_hold cycle=%0d got pop=%b cs_n=%b busy=%b exp pop=0 cs_n=1 busy=0",
                         i, tx_pop, CS_N, busy);
            end
        end
        rx_full = 1'b0;
        #1;
        checks++; if (tx_pop !== 1'b1) begin errors++; $display("FAIL flow_release_pop got=%b exp=1", tx_pop); end
        run_transfer(1'b1, 8'h00, -1, to, gap, cs_low, rises, mb, rx, lat, xpops, ovl);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL flow_timeout got=%b exp=0", to); end
        checks++; if (rx !== 8'h77)   begin errors++; $display("FAIL flow_rx_data got=%h exp=77", rx); end
        tick();
    endtask

    task automatic test_enable_drop();
        enable = 1'b1; tx_data = 8'h5A; tx_empty = 1'b0;
        run_transfer(1'b0, 8'hC3, 4, to, gap, cs_low, rises, mb, rx, lat, xpops, ovl);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL en_timeout got=%b exp=0", to); end
        checks++; if (rx !== 8'h5A)   begin errors++; $display("FAIL en_rx_data got=%h exp=5a", rx); end
        checks++; if (xpops != 0)     begin errors++; $display("FAIL en_extra_pops got=%0d exp=0", xpops); end
        checks++; if (cs_low != 32)   begin errors++; $display("FAIL en_cs_low got=%0d exp=32", cs_low); end
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (tx_pop !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL en_no_pop cycle=%0d got pop=%b busy=%b exp pop=0 busy=0", i, tx_pop, busy);
            end
        end
        enable = 1'b1;
        run_transfer(1'b1, 8'h00, -1, to, gap, cs_low, rises, mb, rx, lat, xpops, ovl);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL en2_timeout got=%b exp=0", to); end
        checks++; if (rx !== 8'hC3)   begin errors++; $display("FAIL en2_rx_data got=%h exp=c3", rx); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic prev_sclk;
        int   nr;
        bit   found;
        enable = 1'b1; tx_data = 8'hFF; tx_empty = 1'b0;
        #1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tx_pop) found = 1;
            else tick();
        end
        @(posedge PCLK);
        #1;
        tx_empty  = 1'b1;
        prev_sclk = 1'b0;
        nr        = 0;
        for (int i = 0; i < 100 && nr < 5; i++) begin
            tick();
            if (SCLK && !prev_sclk) nr++;
            prev_sclk = SCLK;
        end
        checks++; if (nr != 5 || CS_N !== 1'b0 || MOSI !== 1'b1) begin
            errors++; $display("FAIL rm_reach_bit4 got rises=%0d cs_n=%b mosi=%b exp rises=5 cs_n=0 mosi=1", nr, CS_N, MOSI);
        end
        PRESET = 1'b1;
        #1;
        checks++; if (CS_N !== 1'b1)     begin errors++; $display("FAIL rm_cs_n got=%b exp=1", CS_N); end
        checks++; if (SCLK !== 1'b0)     begin errors++; $display("FAIL rm_sclk got=%b exp=0", SCLK); end
        checks++; if (MOSI !== 1'b0)     begin errors++; $display("FAIL rm_mosi got=%b exp=0", MOSI); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data got=%h exp=00", rx_data); end
        repeat (2) tick();
        PRESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (rx_push !== 1'b0 || busy !== 1'b0 || CS_N !== 1'b1) begin
                errors++;
                $display("FAIL rm_idle cycle=%0d got push=%b busy=%b cs_n=%b exp push=0 busy=0 cs_n=1",
                         i, rx_push, busy, CS_N);
            end
        end
        tx_data = 8'h96; tx_empty = 1'b0;
        run_transfer(1'b1, 8'h00, -1, to, gap, cs_low, rises, mb, rx, lat, xpops, ovl);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL rm_next_timeout got=%b exp=0", to); end
        checks++; if (rx !== 8'h96)   begin errors++; $display("FAIL rm_next_rx_data got=%h exp=96", rx); end
        checks++; if (lat != 33)      begin errors++; $display("FAIL rm_next_latency got=%0d exp=33", lat); end
        tick();
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_high();
        test_back_to_back();
        test_flow_control();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_shifter.md
# spi_master_shifter

SPI master shift engine for the APB-to-SPI bridge, sitting directly downstream of the TX FIFO and upstream of the RX FIFO. It pops one byte from the first-word-fall-through TX FIFO and runs one SPI transfer in mode 0 (CPOL=0, CPHA=0), MSB first. It drives SCLK, MOSI and CS_N, samples MISO, and pushes the received byte into the RX FIFO.

## Interface
- DWIDTH, 8: transfer word width in bits, ≥2, equal to the APB data width.
- CLK_DIV, 2: SCLK half-period in PCLK cycles, ≥1.

Ports:
- PCLK  in  1  single system clock; all logic on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- enable  in  1  permits starting new transfers.
- tx_empty  in  1  TX FIFO empty.
- tx_data  in  DWIDTH  TX FIFO head word; valid while tx_empty=0.
- tx_pop  out  1  one-cycle pop strobe to the TX FIFO.
- rx_full  in  1  RX FIFO full.
- rx_data  out  DWIDTH  received word; valid while rx_push=1.
- rx_push  out  1  one-cycle push strobe to the RX FIFO.
- SCLK  out  1  SPI clock; idles low.
- MOSI  out  1  master data out.
- MISO  in  1  slave data in; sampled directly, with no synchronizer.
- CS_N  out  1  active-low chip select.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States are IDLE, START, SHIFT, DONE. Registers are shreg[DWIDTH], miso_q, half-period counter hcnt, bit counter bcnt.
- IDLE:
  - tx_pop is combinational and equals enable & ~tx_empty & ~rx_full.
  - When tx_pop=1, the same edge loads shreg←tx_data, sets CS_N←0, clears hcnt and bcnt, and moves to START.
- START: SCLK=0 for CLK_DIV cycles (MOSI setup), then SCLK←1 and the state moves to SHIFT.
- SHIFT:
  - Every CLK_DIV cycles SCLK toggles.
  - On the edge driving SCLK 0→1: miso_q←MISO.
  - On the edge driving SCLK 1→0, when bcnt<DWIDTH-1: shreg←{shreg[DWIDTH-2:0], miso_q} and bcnt increments.
  - On the 1→0 edge with bcnt=DWIDTH-1 (the last bit):
    - rx_data←{shreg[DWIDTH-2:0], miso_q}
    - rx_push←1
    - CS_N←1
    - SCLK←0
    - next state DONE.
- DONE: lasts one cycle (rx_push high), then returns to IDLE.
- MOSI = shreg[DWIDTH-1] while CS_N=0, and 0 otherwise.
- The RX FIFO is guaranteed room because a transfer never starts while rx_full=1. rx_full is ignored mid-transfer.
- Deasserting enable mid-transfer has no effect; the current word completes, and no new pop occurs.

## Timing
- Reset values:
  - SCLK=0, MOSI=0, CS_N=1
  - tx_pop=0, rx_push=0, rx_data=0, busy=0
  - state=IDLE, all counters 0
- Reset mid-transfer aborts immediately: the in-flight word is lost, there is no rx_push, and CS_N goes high asynchronously.
- Let E0 be the edge ending the tx_pop cycle; CS_N falls at E0.
- Bit k (k=0..DWIDTH-1):
  - SCLK rises at E0+(2k+1)·CLK_DIV.
  - SCLK falls at E0+(2k+2)·CLK_DIV.
- Last fall at E0+2·DWIDTH·CLK_DIV. CS_N rises and rx_push asserts at that same edge.
- CS_N low time = 2·DWIDTH·CLK_DIV cycles (32 for the defaults).
- Back-to-back transfers (tx_empty stays 0): CS_N is high for exactly 2 cycles (DONE, then the IDLE pop cycle).
- Pop-to-push latency = 2·DWIDTH·CLK_DIV+1 cycles, measured from the tx_pop cycle to the rx_push cycle.
- tx_pop and rx_push are never high in the same cycle, and each is exactly one cycle wide.

## Test plan
- Loopback (MISO=MOSI), DWIDTH=8, CLK_DIV=2, push 0xA5:
  - One tx_pop; CS_N low for 32 cycles; 8 SCLK rising edges.
  - MOSI bits 1,0,1,0,0,1,0,1; rx_push once with rx_data=0xA5.
- MISO tied 1, send 0x3C:
  - MOSI shows 0,0,1,1,1,1,0,0 at each SCLK rise; rx_data=0xFF.
- Back-to-back: two words 0x12, 0x34 queued, loopback:
  - rx_data=0x12 then 0x34.
  - CS_N high exactly 2 cycles between transfers; pop-to-push latency 33 cycles each.
- Flow control: rx_full=1 with TX non-empty, held 20 cycles:
  - No tx_pop, CS_N=1, busy=0.
  - Release rx_full → tx_pop on the next cycle.
- Enable drop: deassert enable at bit 3 of word 0x5A with a second word queued:
  - 0x5A completes and is pushed; the second word is not popped until enable returns.
- Reset mid-transfer: assert PRESET at bit 4:
  - Same cycle: CS_N=1, SCLK=0, MOSI=0, busy=0; no rx_push.
  - After release: idle until the next non-empty pop.
